// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and default sizing for the edge event arbiter.
package edge_event_arbiter_pkg;
    localparam int unsigned N_CH_DEF = 4;
    localparam int unsigned ID_W_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;
endpackage

// File: rtl/edge_event_arbiter_if.sv
// Bus between the edge event arbiter and its producer/consumer environment.
interface edge_event_arbiter_if
    import edge_event_arbiter_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned ID_W = ID_W_DEF
);
    logic [N_CH-1:0] data_in;
    logic [N_CH-1:0] ch_enable;
    logic            event_ready;
    logic [N_CH-1:0] ovf_clear;
    logic            event_valid;
    logic [ID_W-1:0] event_id;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] overflow;

    modport master (
        output data_in, ch_enable, event_ready, ovf_clear,
        input  event_valid, event_id, pending, overflow
    );

    modport slave (
        input  data_in, ch_enable, event_ready, ovf_clear,
        output event_valid, event_id, pending, overflow
    );
endinterface

// File: rtl/edge_pending_cell.sv
// One channel: rising-edge detector with a pending flag and a sticky overflow flag.
module edge_pending_cell (
    input  logic clock,
    input  logic reset,
    input  logic data_in,
    input  logic ch_enable,
    input  logic grant,
    input  logic ovf_clear,
    output logic pending,
    output logic overflow
);
    logic prev;
    logic rise;
    logic ovf_set;

    assign rise    = data_in & ~prev;
    assign ovf_set = rise & ch_enable & pending & ~grant;

    always_ff @(posedge clock) begin
        // prev tracks the line even in reset so a held-high line yields no edge
        prev <= data_in;
        if (reset) begin
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (!ch_enable) begin
                pending <= 1'b0;
            end else if (rise) begin
                pending <= 1'b1;
            end else if (grant) begin
                pending <= 1'b0;
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/edge_event_arbiter.sv
// Detects rising edges on N_CH lines and offers them one at a time, round-robin.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned ID_W = ID_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    edge_event_arbiter_if.slave  bus
);
    arb_state_t      state;
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] ovf_q;
    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] grant_vec;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] id_q;
    logic            valid_q;
    logic            fire;

    for (genvar g = 0; g < N_CH; g++) begin : g_cell
        edge_pending_cell u_cell (
            .clock     (clock),
            .reset     (reset),
            .data_in   (bus.data_in[g]),
            .ch_enable (bus.ch_enable[g]),
            .grant     (grant_vec[g]),
            .ovf_clear (bus.ovf_clear[g]),
            .pending   (pend_q[g]),
            .overflow  (ovf_q[g])
        );
    end

    assign eligible = pend_q & bus.ch_enable;

    // Scan from the farthest offset down so the nearest eligible channel after last_grant wins.
    always_comb begin
        sel_id   = '0;
        scan_idx = '0;
        for (int unsigned off = N_CH; off >= 1; off--) begin
            scan_idx = ID_W'((32'(last_grant) + off) % N_CH);
            if (eligible[scan_idx]) begin
                sel_id = scan_idx;
            end
        end
    end

    assign fire      = (|eligible) && (state == IDLE || bus.event_ready);
    assign grant_vec = fire ? (N_CH'(1) << sel_id) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            id_q       <= '0;
            last_grant <= ID_W'(N_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        state      <= OFFER;
                        valid_q    <= 1'b1;
                        id_q       <= sel_id;
                        last_grant <= sel_id;
                    end
                end
                OFFER: begin
                    if (bus.event_ready) begin
                        if (fire) begin
                            id_q       <= sel_id;
                            last_grant <= sel_id;
                        end else begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.event_valid = valid_q;
    assign bus.event_id    = id_q;
    assign bus.pending     = pend_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench: cycle table for flag behaviour, scoreboard for accepted event order.
module tb_edge_event_arbiter;
    logic clock;
    logic reset;

    edge_event_arbiter_if #(.N_CH(4), .ID_W(2)) bus ();

    edge_event_arbiter #(.N_CH(4), .ID_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] en;
        logic       rdy;
        logic [3:0] clr;
        logic       push;
        logic [1:0] push_id;
        logic       v;
        logic [1:0] id;
        logic [3:0] p;
        logic [3:0] o;
    } vec_t;

    vec_t     tbl [27];
    int       errors = 0;
    int       checks = 0;
    int       exp_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Pops the scoreboard on a handshake seen just before the edge, then advances one cycle.
    task automatic step();
        int e;
        if (bus.event_valid === 1'b1 && bus.event_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handshake at %0t: actual id=%0d required no event", $time, bus.event_id);
            end else begin
                e = exp_q.pop_front();
                if (bus.event_id !== 2'(e)) begin
                    errors++;
                    $display("FAIL handshake at %0t: actual id=%0d required id=%0d", $time, bus.event_id, e);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic [3:0] en, input logic rdy, input logic [3:0] clr);
        bus.data_in     = d;
        bus.ch_enable   = en;
        bus.event_ready = rdy;
        bus.ovf_clear   = clr;
    endtask

    initial begin
        //          d        en      rdy  clr     push id  v     id     p        o
        tbl[0]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0100, 4'b0000};
        tbl[2]  = '{4'b0100, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0100, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd2, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd2, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0010, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 2'd2, 4'b0010, 4'b0000};
        tbl[6]  = '{4'b0010, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0010, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 4'b0000};
        tbl[9]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 4'b0000};
        tbl[10] = '{4'b0010, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd1, 4'b0010, 4'b0010};
        tbl[11] = '{4'b0010, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 4'b0000};
        tbl[12] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 4'b0000};
        tbl[13] = '{4'b0010, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd1, 4'b0010, 4'b0000};
        tbl[14] = '{4'b0010, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd1, 4'b0000, 4'b0000};
        tbl[16] = '{4'b1000, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd1, 4'b1000, 4'b0000};
        tbl[17] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0000, 4'b0000};
        tbl[18] = '{4'b0010, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0010, 4'b0000};
        tbl[19] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0010, 4'b0000};
        tbl[20] = '{4'b0010, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0010, 4'b0010};
        tbl[21] = '{4'b0000, 4'b1101, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0000, 4'b0010};
        tbl[22] = '{4'b0010, 4'b1101, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0000, 4'b0010};
        tbl[23] = '{4'b0000, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0000, 4'b0000};
        tbl[24] = '{4'b0000, 4'b0111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0000, 4'b0000};
        tbl[25] = '{4'b0000, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd3, 4'b0000, 4'b0000};
        tbl[26] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd3, 4'b0000, 4'b0000};

        reset = 1'b1;
        drive(4'b0000, 4'b1111, 1'b0, 4'b0000);
        step();
        step();
        check("reset_valid", 8'(bus.event_valid), 8'h0);
        check("reset_id", 8'(bus.event_id), 8'h0);
        check("reset_pending", 8'(bus.pending), 8'h0);
        check("reset_overflow", 8'(bus.overflow), 8'h0);
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].d, tbl[i].en, tbl[i].rdy, tbl[i].clr);
            if (tbl[i].push) exp_q.push_back(int'(tbl[i].push_id));
            step();
            check($sformatf("tbl%0d_valid", i), 8'(bus.event_valid), 8'(tbl[i].v));
            check($sformatf("tbl%0d_id", i), 8'(bus.event_id), 8'(tbl[i].id));
            check($sformatf("tbl%0d_pending", i), 8'(bus.pending), 8'(tbl[i].p));
            check($sformatf("tbl%0d_overflow", i), 8'(bus.overflow), 8'(tbl[i].o));
        end

        // Simultaneous edges on all channels: back-to-back grants 0..3.
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        step();
        check("simul_pending", 8'(bus.pending), 8'hF);
        check("simul_idle", 8'(bus.event_valid), 8'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("simul_valid%0d", i), 8'(bus.event_valid), 8'h1);
            check($sformatf("simul_id%0d", i), 8'(bus.event_id), 8'(i));
            check($sformatf("simul_pend%0d", i), 8'(bus.pending), 8'((4'b1111 << (i + 1)) & 4'hF));
        end
        step();
        check("simul_done", 8'(bus.event_valid), 8'h0);
        drive(4'b0000, 4'b1111, 1'b1, 4'b0000);
        step();

        // Fairness: channels 0 and 3 retrigger together every 4 cycles.
        for (int r = 0; r < 3; r++) begin
            drive(4'b1001, 4'b1111, 1'b1, 4'b0000);
            exp_q.push_back(0);
            exp_q.push_back(3);
            step();
            check($sformatf("fair%0d_pending", r), 8'(bus.pending), 8'h9);
            drive(4'b0000, 4'b1111, 1'b1, 4'b0000);
            step();
            check($sformatf("fair%0d_first", r), 8'(bus.event_id), 8'd0);
            step();
            check($sformatf("fair%0d_second", r), 8'(bus.event_id), 8'd3);
            check($sformatf("fair%0d_valid", r), 8'(bus.event_valid), 8'h1);
            step();
            check($sformatf("fair%0d_idle", r), 8'(bus.event_valid), 8'h0);
        end

        // Reset while offering: event dropped, held-high lines produce no edge.
        drive(4'b1111, 4'b1111, 1'b0, 4'b0000);
        step();
        step();
        check("rst_pre_valid", 8'(bus.event_valid), 8'h1);
        check("rst_pre_id", 8'(bus.event_id), 8'd0);
        reset = 1'b1;
        step();
        step();
        check("rst_mid_valid", 8'(bus.event_valid), 8'h0);
        check("rst_mid_pending", 8'(bus.pending), 8'h0);
        reset = 1'b0;
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_post_valid%0d", i), 8'(bus.event_valid), 8'h0);
            check($sformatf("rst_post_pending%0d", i), 8'(bus.pending), 8'h0);
        end
        drive(4'b0000, 4'b1111, 1'b1, 4'b0000);
        step();
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rst_order%0d", i), 8'(bus.event_id), 8'(i));
        end
        step();
        check("rst_order_done", 8'(bus.event_valid), 8'h0);

        check("scoreboard_empty", 8'(exp_q.size()), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of monitored input lines (2..8).
REQ-002 Parameter ID_W, default 2, width of event_id; the design SHALL support only ID_W = clog2(N_CH).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  N_CH  asynchronous-free level inputs, one per channel, sampled on clock.
REQ-006 ch_enable  input  N_CH  per-channel enable; 0 masks the channel.
REQ-007 event_ready  input  1  consumer accepts the offered event.
REQ-008 ovf_clear  input  N_CH  write-1-to-clear for the overflow flags.
REQ-009 event_valid  output  1  an event is offered.
REQ-010 event_id  output  ID_W  channel number of the offered event.
REQ-011 pending  output  N_CH  per-channel detected-but-not-yet-granted flags.
REQ-012 overflow  output  N_CH  sticky per-channel lost-edge flags.

Function
REQ-013 Per channel, the block SHALL register data_in into prev, and SHALL flag rise[i] when data_in[i]=1 and prev[i]=0 at a clock edge.
REQ-014 When rise[i] and ch_enable[i] hold at clock edge k, the block SHALL set pending[i] after edge k.
REQ-015 When rise[i] occurs while pending[i] is already 1 and is not being cleared at that edge, the block SHALL set overflow[i]; pending[i] SHALL stay 1.
REQ-016 When pending[i] is cleared by a grant at the same edge a new rise[i] arrives, set SHALL win: pending[i] stays 1 and overflow[i] does not change.
REQ-017 When ch_enable[i]=0, the block SHALL ignore rise[i] and clear pending[i] at the next edge; overflow[i] SHALL be held.
REQ-018 overflow[i] SHALL clear on an edge where ovf_clear[i]=1, unless a new overflow for channel i occurs at that same edge, in which case set wins.
REQ-019 The FSM SHALL have two states: IDLE (event_valid=0) and OFFER (event_valid=1).
REQ-020 In IDLE, when any bit of pending & ch_enable is set, the block SHALL grant one channel by round-robin. It SHALL load event_id, clear that pending bit, and enter OFFER at the same edge.
REQ-021 Round-robin SHALL search from (last_grant+1) mod N_CH upward with wrap-around; after reset, last_grant SHALL be N_CH-1, so channel 0 has first priority.
REQ-022 In OFFER, event_valid and event_id SHALL stay stable until an edge where event_ready=1.
REQ-023 On an edge in OFFER where event_ready=1: if another eligible pending bit exists, the block SHALL grant it at that edge and stay in OFFER (back-to-back, no bubble); otherwise it SHALL go to IDLE.
REQ-024 Latency: if data_in[i] is first sampled high at edge k with the block idle and no other pending, event_valid SHALL be 1 after edge k+1.
REQ-025 An event already offered SHALL remain offered if its channel is disabled afterwards.
REQ-026 event_ready while in IDLE SHALL be ignored.

Reset
REQ-027 While reset=1 at an edge, the block SHALL force pending, overflow and event_valid to 0, event_id to 0, the FSM to IDLE, and last_grant to N_CH-1.
REQ-028 While reset=1, prev SHALL load data_in, so a line held high across reset release produces no edge.
REQ-029 Reset asserted in OFFER SHALL drop the offered event without handshake.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE, OFFER) and the N_CH/ID_W defaults.
REQ-031 The per-channel edge detection, pending flag and overflow flag SHALL be one sub-module, edge_pending_cell, instantiated N_CH times.
REQ-032 The round-robin selection SHALL be combinational in the top level and SHALL be a function of pending, ch_enable and last_grant only.

Verification
REQ-033 Single edge: all channels enabled, data_in[2] goes 0->1 at edge 10, event_ready=1 -> event_valid=1, event_id=2 after edge 11, then 0 after edge 12.
REQ-034 Simultaneous edges: data_in goes 0000->1111 in one cycle, event_ready held 1 -> event_id is 0,1,2,3 on consecutive cycles with no gap, then event_valid=0.
REQ-035 Fairness: channels 0 and 3 retrigger every 4 cycles, event_ready=1 -> grants alternate 0,3,0,3; channel 0 never wins twice in a row while 3 is pending.
REQ-036 Overflow: event_ready=0, two rising edges on channel 1 -> pending[1]=1, overflow[1]=1; then ovf_clear=0010 -> overflow[1]=0, pending[1] still 1.
REQ-037 Set-wins and stall: while offering channel 1, hold event_ready=0 for 5 cycles -> event_id stays 1; a rise on channel 1 at the accept edge leaves pending[1]=1.
REQ-038 Reset: data_in=1111 and reset mid-OFFER, then reset released -> event_valid=0 and pending=0000 with no event generated; the next grant order starts at channel 0.
